mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter RD_LAT, default 1, RAM read latency in cycles (1..3).
REQ-004 Parameter MAX_D_BURST, default 4, consecutive data grants allowed while a fetch waits.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low; one clock.
REQ-007 i_req  in  1  fetch requester: read request, held high until i_ack.
REQ-008 i_addr  in  ADDR_W  fetch word address.
REQ-009 i_rdata  out  DATA_W  fetch read data, valid while i_ack=1.
REQ-010 i_ack  out  1  one-cycle fetch completion pulse.
REQ-011 d_req  in  1  load/store requester: request, held high until d_ack.
REQ-012 d_we  in  1  1=store, 0=load.
REQ-013 d_addr  in  ADDR_W  data word address.
REQ-014 d_wdata  in  DATA_W  store data, already byte/half formatted.
REQ-015 d_rdata  out  DATA_W  load data, valid while d_ack=1.
REQ-016 d_ack  out  1  one-cycle data completion pulse.
REQ-017 addr  out  ADDR_W  RAM address.
REQ-018 ram_in  out  DATA_W  RAM write data.
REQ-019 ram_en  out  1  RAM write enable.
REQ-020 ram_out  in  DATA_W  RAM read data, valid RD_LAT cycles after addr is presented.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 owner  out  1  current/last grantee: 0=fetch, 1=data.

Function
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-024 IDLE: if any req is high, the block SHALL pick a winner, latch its addr, we (0 for fetch) and wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-025 Winner selection: data wins by default; fetch wins when both requests are high and d_streak==MAX_D_BURST; a single requester always wins.
REQ-026 d_streak SHALL increment (saturating) on a data grant while i_req=1, clear on any fetch grant, and stay unchanged otherwise.
REQ-027 ISSUE (1 cycle): addr and ram_in SHALL be driven from the latched copies, and ram_en SHALL equal the latched we.
REQ-028 WAIT (RD_LAT cycles, counted by a latency counter): addr SHALL be held and ram_en SHALL be 0; on the last WAIT cycle, ram_out SHALL be registered into the owner's rdata register.
REQ-029 RESP (1 cycle): the owner's ack SHALL be 1 and the other ack SHALL be 0, then the FSM SHALL return to IDLE.
REQ-030 Latency: a req sampled in IDLE at cycle t SHALL produce ack at cycle t+2+RD_LAT; stores SHALL follow the same timing, with rdata left unchanged.
REQ-031 Requests SHALL be sampled only in IDLE; requester input changes after the grant SHALL be ignored, because the latched copies are used.
REQ-032 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-033 ram_en SHALL be 1 in no state other than ISSUE with a latched store.
REQ-034 At most one ack SHALL be high in any cycle.
REQ-035 i_rdata and d_rdata SHALL each hold their value until the next completion for that requester.

Reset
REQ-036 When rst=0 at a clock edge, the block SHALL go to IDLE and clear the following to 0: i_ack, d_ack, ram_en, addr, ram_in, i_rdata, d_rdata, busy, owner, d_streak and the latency counter.
REQ-037 A reset during ISSUE, WAIT or RESP SHALL abort the transaction without an ack.
REQ-038 A store already in ISSUE at the reset edge SHALL still complete in RAM.

Structure
REQ-039 The shared package mem_arb_pkg SHALL hold the state enum, the owner encoding (OWN_I=0, OWN_D=1) and the default parameter values.
REQ-040 Winner selection SHALL be one combinational sub-module, mem_arb_pick, with inputs i_req, d_req, d_streak and MAX_D_BURST and output owner_next.
REQ-041 The FSM, latches, counters and rdata registers SHALL live in mem_port_arbiter.

Verification
REQ-042 Single fetch, RD_LAT=1, RAM[0x10]=0xDEADBEEF, i_req=1 with i_addr=0x10 at cycle 0 -> i_ack=1 at cycle 3, i_rdata=0xDEADBEEF, and ram_en stays 0 throughout.
REQ-043 Store then load: d_we=1, d_addr=0x20, d_wdata=0x12345678 -> ram_en=1 for exactly one cycle with addr=0x20; a following load of 0x20 -> d_rdata=0x12345678.
REQ-044 Simultaneous requests, d_streak=0 -> data is served first, fetch second, with acks 4 cycles apart.
REQ-045 Starvation: i_req and d_req held high for 6 transactions with MAX_D_BURST=4 -> grant order D,D,D,D,I,D.
REQ-046 rst=0 during WAIT of a load -> no d_ack, all outputs 0 next cycle, and a request after reset completes normally.
REQ-047 RD_LAT=3, fetch of 0x05 -> ack at cycle 5, and addr is held at 0x05 from ISSUE through WAIT.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester single-port RAM arbiter.
// Owner encoding, FSM state enum and parameter defaults live here so the checkers can use them.
package mem_arb_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_RD_LAT      = 1;
  localparam int DEF_MAX_D_BURST = 4;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Width of the data-streak counter; it must be able to hold max_burst itself.
  function automatic int streak_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the arbiter: one fetch port and one load/store port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Handshake: a requester raises req with its command and holds both until the
  // matching one-cycle ack; rdata is valid while ack is high and then holds until
  // that requester's next ack. A req still high after its ack is a new request.
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_rdata, i_ack, d_rdata, d_ack
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_rdata, i_ack, d_rdata, d_ack
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection: data by default, fetch once the data streak reaches its limit.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_BURST = DEF_MAX_D_BURST,
  parameter int SW          = streak_w(MAX_D_BURST)
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] d_streak,
  output logic          owner_next
);

  always_comb begin
    owner_next = OWN_D;
    if (!d_req) begin
      owner_next = OWN_I;
    end else if (i_req && (d_streak == SW'(MAX_D_BURST))) begin
      owner_next = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between a fetch and a load/store requester.
// Each transaction walks IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]  addr,
  output logic [DATA_W-1:0]  ram_in,
  output logic               ram_en,
  input  logic [DATA_W-1:0]  ram_out,
  output logic               busy,
  output logic               owner,
  output arb_state_t         dbg_state
);

  localparam int SW = streak_w(MAX_D_BURST);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;
  logic [SW-1:0]     d_streak;
  logic [1:0]        lat_cnt;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              owner_next;
  logic              any_req;
  logic              lat_last;
  logic              grant;

  assign any_req  = bus.i_req | bus.d_req;
  assign lat_last = (lat_cnt == 2'(RD_LAT - 1));
  assign grant    = (state == ST_IDLE) && any_req;

  mem_arb_pick #(
    .MAX_D_BURST (MAX_D_BURST)
  ) u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .d_streak   (d_streak),
    .owner_next (owner_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (lat_last) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Command latches are the only source for the RAM side once granted, so
  // requester inputs may change freely after the grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      owner_q   <= OWN_I;
      d_streak  <= '0;
      lat_cnt   <= 2'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= owner_next;
        if (owner_next == OWN_D) begin
          addr_q  <= bus.d_addr;
          we_q    <= bus.d_we;
          wdata_q <= bus.d_wdata;
          if (bus.i_req && (d_streak != SW'(MAX_D_BURST))) begin
            d_streak <= d_streak + 1'b1;
          end
        end else begin
          addr_q   <= bus.i_addr;
          we_q     <= 1'b0;
          wdata_q  <= '0;
          d_streak <= '0;
        end
      end

      lat_cnt <= ((state == ST_WAIT) && !lat_last) ? lat_cnt + 2'd1 : 2'd0;

      if ((state == ST_WAIT) && lat_last && !we_q) begin
        if (owner_q == OWN_D) begin
          d_rdata_q <= ram_out;
        end else begin
          i_rdata_q <= ram_out;
        end
      end
    end
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    owner       = owner_q;
    addr        = addr_q;
    ram_in      = wdata_q;
    ram_en      = (state == ST_ISSUE) && we_q;
    bus.i_ack   = (state == ST_RESP) && (owner_q == OWN_I);
    bus.d_ack   = (state == ST_RESP) && (owner_q == OWN_D);
    bus.i_rdata = i_rdata_q;
    bus.d_rdata = d_rdata_q;
    dbg_state   = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 instance with scoreboard, plus an RD_LAT=3 instance.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus_b ();

  logic [7:0]  addr_a, addr_b;
  logic [31:0] ram_in_a, ram_out_a, ram_in_b, ram_out_b;
  logic        ram_en_a, ram_en_b, busy_a, busy_b, owner_a, owner_b;
  arb_state_t  dbg_a, dbg_b;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .MAX_D_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .addr(addr_a), .ram_in(ram_in_a),
    .ram_en(ram_en_a), .ram_out(ram_out_a), .busy(busy_a), .owner(owner_a), .dbg_state(dbg_a)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3), .MAX_D_BURST(4)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .addr(addr_b), .ram_in(ram_in_b),
    .ram_en(ram_en_b), .ram_out(ram_out_b), .busy(busy_b), .owner(owner_b), .dbg_state(dbg_b)
  );

  // ---------------- RAM models ----------------
  logic [31:0] mem_a [256];
  logic [31:0] rd_a;
  always @(posedge clk) begin
    if (!rst) begin
      mem_a[8'h10] <= 32'hDEADBEEF;
      mem_a[8'h30] <= 32'hC0FFEE30;
    end else if (ram_en_a) begin
      mem_a[addr_a] <= ram_in_a;
    end
    rd_a <= mem_a[addr_a];
  end
  assign ram_out_a = rd_a;

  logic [31:0] mem_b [256];
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    if (!rst) begin
      mem_b[8'h05] <= 32'hA5A50005;
    end else if (ram_en_b) begin
      mem_b[addr_b] <= ram_in_b;
    end
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ram_out_b = pipe_b[2];

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] shadow_i, shadow_d;
  int          en_cycles;
  logic [7:0]  en_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_fetch(input logic [7:0] a);
    shadow_i = ref_mem[a];
    exp_q.push_back({OWN_I, shadow_i});
  endtask

  task automatic exp_load(input logic [7:0] a);
    shadow_d = ref_mem[a];
    exp_q.push_back({OWN_D, shadow_d});
  endtask

  task automatic exp_store(input logic [7:0] a, input logic [31:0] wd);
    ref_mem[a] = wd;
    exp_q.push_back({OWN_D, shadow_d});
  endtask

  // One cycle: advance to the falling edge and check any completion against the queue.
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    if (ram_en_a) begin
      en_cycles++;
      en_addr = addr_a;
    end
    if (bus_a.i_ack || bus_a.d_ack) begin
      check("ack_onehot", {63'd0, bus_a.i_ack & bus_a.d_ack}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {62'd0, bus_a.i_ack, bus_a.d_ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_owner", {63'd0, bus_a.d_ack}, {63'd0, e[32]});
        check("owner_out", {63'd0, owner_a}, {63'd0, e[32]});
        check("rdata", {32'd0, (e[32] ? bus_a.d_rdata : bus_a.i_rdata)}, {32'd0, e[31:0]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit hold, output int n, output bit was_d);
    bit done;
    n = 0;
    was_d = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      n++;
      if (bus_a.i_ack || bus_a.d_ack) begin
        done = 1'b1;
        was_d = bus_a.d_ack;
        if (!hold) begin
          if (bus_a.i_ack) bus_a.i_req = 1'b0;
          if (bus_a.d_ack) bus_a.d_req = 1'b0;
        end
      end
    end
    if (!done) check("ack_seen", {63'd0, bus_a.i_ack | bus_a.d_ack}, 64'd1);
  endtask

  task automatic drive_fetch(input logic [7:0] a);
    bus_a.i_addr = a;
    bus_a.i_req  = 1'b1;
  endtask

  task automatic drive_data(input logic we, input logic [7:0] a, input logic [31:0] wd);
    bus_a.d_we    = we;
    bus_a.d_addr  = a;
    bus_a.d_wdata = wd;
    bus_a.d_req   = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int         n;
    bit         wd;
    logic [5:0] order;
    logic [7:0] written;
    logic [7:0] ra;
    int         op;
    bit         done;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    ref_mem[8'h10] = 32'hDEADBEEF;
    ref_mem[8'h30] = 32'hC0FFEE30;
    shadow_i = '0;
    shadow_d = '0;
    en_cycles = 0;
    en_addr = '0;
    bus_a.i_req = 0; bus_a.i_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.i_req = 0; bus_b.i_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0;

    rst = 1'b0;
    repeat (3) step();
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_state", {62'd0, dbg_a}, {62'd0, ST_IDLE});
    check("rst_addr", {56'd0, addr_a}, 64'd0);
    check("rst_ram_in", {32'd0, ram_in_a}, 64'd0);
    check("rst_ram_en", {63'd0, ram_en_a}, 64'd0);
    check("rst_acks", {62'd0, bus_a.i_ack, bus_a.d_ack}, 64'd0);
    check("rst_owner", {63'd0, owner_a}, 64'd0);
    check("rst_rdata", {bus_a.i_rdata, bus_a.d_rdata}, 64'd0);
    rst = 1'b1;
    step();

    // single fetch; address scrambled after the grant
    en_cycles = 0;
    exp_fetch(8'h10);
    drive_fetch(8'h10);
    step();
    bus_a.i_addr = 8'h77;
    wait_ack(1'b0, n, wd);
    check("fetch_latency", 64'(n + 1), 64'd3);
    check("fetch_no_write", 64'(en_cycles), 64'd0);
    step();
    check("i_rdata_hold", {32'd0, bus_a.i_rdata}, {32'd0, 32'hDEADBEEF});

    // store, with the data inputs scrambled after the grant
    en_cycles = 0;
    exp_store(8'h20, 32'h12345678);
    drive_data(1'b1, 8'h20, 32'h12345678);
    step();
    bus_a.d_wdata = 32'hFFFFFFFF;
    bus_a.d_addr  = 8'h21;
    wait_ack(1'b0, n, wd);
    check("store_latency", 64'(n + 1), 64'd3);
    check("store_en_cycles", 64'(en_cycles), 64'd1);
    check("store_en_addr", {56'd0, en_addr}, 64'h20);
    step();

    // load back
    en_cycles = 0;
    exp_load(8'h20);
    drive_data(1'b0, 8'h20, 32'd0);
    wait_ack(1'b0, n, wd);
    check("load_latency", 64'(n), 64'd3);
    check("load_no_write", 64'(en_cycles), 64'd0);
    step();

    // simultaneous requests: data first, fetch four cycles later
    exp_load(8'h30);
    exp_fetch(8'h10);
    drive_data(1'b0, 8'h30, 32'd0);
    drive_fetch(8'h10);
    wait_ack(1'b0, n, wd);
    check("sim_first_is_d", {63'd0, wd}, 64'd1);
    check("sim_first_latency", 64'(n), 64'd3);
    wait_ack(1'b0, n, wd);
    check("sim_second_is_i", {63'd0, wd}, 64'd0);
    check("sim_ack_gap", 64'(n), 64'd4);
    step();

    // starvation guard: both held for six transactions
    order = '0;
    for (int k = 0; k < 4; k++) exp_load(8'h30);
    exp_fetch(8'h10);
    exp_load(8'h30);
    drive_data(1'b0, 8'h30, 32'd0);
    drive_fetch(8'h10);
    for (int k = 0; k < 6; k++) begin
      wait_ack(1'b1, n, wd);
      order = {order[4:0], wd};
      check("starve_gap", 64'(n), (k == 0) ? 64'd3 : 64'd4);
    end
    bus_a.i_req = 1'b0;
    bus_a.d_req = 1'b0;
    check("starve_order", {58'd0, order}, 64'b111101);
    step();
    step();
    check("starve_idle", {63'd0, busy_a}, 64'd0);

    // random loads/stores/fetches over a small address window
    written = '0;
    for (int t = 0; t < 10; t++) begin
      op = $urandom_range(0, 2);
      ra = 8'h40 + 8'($urandom_range(0, 7));
      if (op != 2 && !written[ra[2:0]]) op = 2;
      en_cycles = 0;
      case (op)
        0: begin exp_fetch(ra); drive_fetch(ra); end
        1: begin exp_load(ra); drive_data(1'b0, ra, 32'd0); end
        default: begin
          logic [31:0] rv;
          rv = $urandom;
          exp_store(ra, rv);
          drive_data(1'b1, ra, rv);
          written[ra[2:0]] = 1'b1;
        end
      endcase
      wait_ack(1'b0, n, wd);
      check("rand_latency", 64'(n), 64'd3);
      check("rand_en_cycles", 64'(en_cycles), (op == 2) ? 64'd1 : 64'd0);
      bus_a.d_we = 1'b0;
      step();
    end

    // reset in WAIT of a load aborts it with no ack
    drive_data(1'b0, 8'h30, 32'd0);
    step();
    step();
    check("abort_in_wait", {62'd0, dbg_a}, {62'd0, ST_WAIT});
    rst = 1'b0;
    bus_a.d_req = 1'b0;
    step();
    check("abort_busy", {63'd0, busy_a}, 64'd0);
    check("abort_acks", {62'd0, bus_a.i_ack, bus_a.d_ack}, 64'd0);
    check("abort_addr", {56'd0, addr_a}, 64'd0);
    check("abort_ram", {31'd0, ram_en_a, ram_in_a}, 64'd0);
    check("abort_owner", {63'd0, owner_a}, 64'd0);
    check("abort_rdata", {bus_a.i_rdata, bus_a.d_rdata}, 64'd0);
    rst = 1'b1;
    shadow_i = '0;
    shadow_d = '0;
    step();
    exp_fetch(8'h10);
    drive_fetch(8'h10);
    wait_ack(1'b0, n, wd);
    check("post_reset_latency", 64'(n), 64'd3);
    step();

    // RD_LAT=3 instance: fetch of 0x05
    bus_b.i_addr = 8'h05;
    bus_b.i_req  = 1'b1;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      n++;
      if (dbg_b == ST_ISSUE || dbg_b == ST_WAIT) check("lat3_addr_hold", {56'd0, addr_b}, 64'h05);
      if (bus_b.i_ack) begin
        done = 1'b1;
        check("lat3_rdata", {32'd0, bus_b.i_rdata}, {32'd0, 32'hA5A50005});
        check("lat3_ram_en", {63'd0, ram_en_b}, 64'd0);
      end
    end
    bus_b.i_req = 1'b0;
    check("lat3_latency", 64'(n), 64'd5);

    step();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
